// File: rtl/mem_arbiter.sv
// Two-requester cacheline arbiter: shares one memory port between I-cache and D-cache,
// one whole-line transaction at a time, alternating grants on simultaneous requests.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, COOLDOWN} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t            state;
  grant_t            last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              is_write_q;

  logic d_req;
  logic pick_i;
  logic pick_d;
  logic serving;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    d_req  = d_read | d_write;
    pick_i = i_read && (!d_req || last_grant == GRANT_D);
    pick_d = d_req && (!i_read || last_grant == GRANT_I);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_i) begin
            state      <= SERVE_I;
            addr_q     <= i_addr;
            is_write_q <= 1'b0;
            last_grant <= GRANT_I;
          end else if (pick_d) begin
            state      <= SERVE_D;
            addr_q     <= d_addr;
            wdata_q    <= d_wdata;
            is_write_q <= d_write;
            last_grant <= GRANT_D;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) state <= COOLDOWN;
        end
        COOLDOWN: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Strobes depend on registered state only; resp is the lone path from mem_resp.
  always_comb begin
    serving   = (state == SERVE_I) || (state == SERVE_D);
    mem_read  = serving && !is_write_q;
    mem_write = serving && is_write_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_resp    = (state == SERVE_I) && mem_resp;
    d_resp    = (state == SERVE_D) && mem_resp;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: lone requests, tie alternation,
// read+write conflict, reset mid-transaction and spurious memory responses.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int unsigned errors = 0;
  int unsigned checks = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_strobes(input string tag, input logic rd, input logic wr);
    check({tag, " mem_read"}, LINE_W'(mem_read), LINE_W'(rd));
    check({tag, " mem_write"}, LINE_W'(mem_write), LINE_W'(wr));
  endtask

  task automatic check_resps(input string tag, input logic ir, input logic dr);
    check({tag, " i_resp"}, LINE_W'(i_resp), LINE_W'(ir));
    check({tag, " d_resp"}, LINE_W'(d_resp), LINE_W'(dr));
  endtask

  logic [LINE_W-1:0] line_aa;
  logic [LINE_W-1:0] line_wb;
  logic [ADDR_W-1:0] exp_addr;
  logic              exp_i;

  initial begin
    line_aa   = {(LINE_W/8){8'hAA}};
    line_wb   = {(LINE_W/32){32'h12345678}};
    rst       = 1'b1;
    i_read    = 1'b0;
    i_addr    = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_resp  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_strobes("reset", 1'b0, 1'b0);
    check("reset mem_addr", LINE_W'(mem_addr), '0);
    check("reset mem_wdata", mem_wdata, '0);
    check_resps("reset", 1'b0, 1'b0);

    // Lone I read, memory answers 4 cycles after the strobe appears
    i_read = 1'b1;
    i_addr = 32'h0000_0060;
    tick();
    check_strobes("iread grant", 1'b1, 1'b0);
    check("iread mem_addr", LINE_W'(mem_addr), LINE_W'(32'h60));
    for (int k = 0; k < 3; k++) begin
      tick();
      check_strobes("iread hold", 1'b1, 1'b0);
      check_resps("iread wait", 1'b0, 1'b0);
    end
    tick();
    mem_rdata = line_aa;
    mem_resp  = 1'b1;
    #1;
    check_resps("iread done", 1'b1, 1'b0);
    check("iread i_rdata", i_rdata, line_aa);
    tick();
    mem_resp = 1'b0;
    i_read   = 1'b0;
    check_strobes("iread cooldown", 1'b0, 1'b0);
    check_resps("iread cooldown", 1'b0, 1'b0);
    tick();

    // Lone D write-back with address changing mid-service
    d_write = 1'b1;
    d_addr  = 32'h0000_1000;
    d_wdata = line_wb;
    tick();
    check_strobes("dwrite grant", 1'b0, 1'b1);
    check("dwrite mem_addr", LINE_W'(mem_addr), LINE_W'(32'h1000));
    check("dwrite mem_wdata", mem_wdata, line_wb);
    d_addr  = 32'hFFFF_FFE0;
    d_wdata = '0;
    tick();
    check("dwrite addr held", LINE_W'(mem_addr), LINE_W'(32'h1000));
    check("dwrite wdata held", mem_wdata, line_wb);
    check_strobes("dwrite hold", 1'b0, 1'b1);
    mem_resp = 1'b1;
    #1;
    check_resps("dwrite done", 1'b0, 1'b1);
    tick();
    mem_resp = 1'b0;
    d_write  = 1'b0;
    check_resps("dwrite cooldown", 1'b0, 1'b0);
    tick();

    // Tie alternation from reset: I, D, I, D with next strobe 3 cycles after mem_resp
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    i_read = 1'b1;
    i_addr = 32'h0000_0100;
    d_read = 1'b1;
    d_addr = 32'h0000_0200;
    tick();
    for (int g = 0; g < 4; g++) begin
      exp_i    = (g % 2 == 0);
      exp_addr = exp_i ? 32'h0000_0100 : 32'h0000_0200;
      check_strobes("tie strobe", 1'b1, 1'b0);
      check("tie mem_addr", LINE_W'(mem_addr), LINE_W'(exp_addr));
      mem_resp = 1'b1;
      #1;
      check_resps("tie resp", exp_i, !exp_i);
      tick();
      mem_resp = 1'b0;
      if (g == 3) begin
        i_read = 1'b0;
        d_read = 1'b0;
      end
      check_strobes("tie cooldown", 1'b0, 1'b0);
      tick();
      check_strobes("tie idle", 1'b0, 1'b0);
      if (g != 3) tick();
    end

    // Read+write conflict is treated as a write, then reset mid-transaction
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h0000_0300;
    tick();
    check_strobes("rw conflict", 1'b0, 1'b1);
    rst     = 1'b1;
    d_read  = 1'b0;
    d_write = 1'b0;
    tick();
    rst = 1'b0;
    check_strobes("mid reset", 1'b0, 1'b0);
    check_resps("mid reset", 1'b0, 1'b0);
    mem_resp = 1'b1;
    #1;
    check_resps("late mem_resp", 1'b0, 1'b0);
    tick();
    mem_resp = 1'b0;
    i_read   = 1'b1;
    i_addr   = 32'h0000_0400;
    tick();
    check_strobes("post reset grant", 1'b1, 1'b0);
    check("post reset mem_addr", LINE_W'(mem_addr), LINE_W'(32'h400));
    mem_resp = 1'b1;
    #1;
    check_resps("post reset resp", 1'b1, 1'b0);
    tick();
    mem_resp = 1'b0;
    i_read   = 1'b0;
    tick();

    // Spurious mem_resp in IDLE: no resp, no state change
    mem_resp = 1'b1;
    #1;
    check_resps("spurious", 1'b0, 1'b0);
    tick();
    mem_resp = 1'b0;
    check_strobes("spurious after", 1'b0, 1'b0);
    d_read = 1'b1;
    d_addr = 32'h0000_0500;
    tick();
    check_strobes("spurious then grant", 1'b1, 1'b0);
    check("spurious then addr", LINE_W'(mem_addr), LINE_W'(32'h500));
    d_read = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
